// File: rtl/sprite_linebuf_banked_pkg.sv
// Shared defaults and erase FSM encoding for the banked sprite line buffer.
package sprite_linebuf_banked_pkg;

    localparam int SPR_LINE_PIXELS = 640;
    localparam int SPR_DATA_WIDTH  = 16;
    localparam int SPR_BANK_BITS   = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ERASE = 1'b1;

endpackage

// File: rtl/sprite_linebuf_banked_if.sv
// Renderer/composer side of the line buffer, plus the buffer-select line.
interface sprite_linebuf_banked_if #(
    parameter int IDX_W      = 10,
    parameter int DATA_WIDTH = 16
);
    logic                  active_render_buffer;
    logic [IDX_W-1:0]      renderer_rd_idx;
    logic [DATA_WIDTH-1:0] renderer_rd_data;
    logic [IDX_W-1:0]      renderer_wr_idx;
    logic [DATA_WIDTH-1:0] renderer_wr_data;
    logic                  renderer_wr_en;
    logic [IDX_W-1:0]      composer_rd_idx;
    logic [DATA_WIDTH-1:0] composer_rd_data;
    logic                  composer_erase_start;
    logic                  composer_erase_busy;
    logic                  composer_erase_abort;

    modport master (
        output active_render_buffer,
        output renderer_rd_idx,
        input  renderer_rd_data,
        output renderer_wr_idx,
        output renderer_wr_data,
        output renderer_wr_en,
        output composer_rd_idx,
        input  composer_rd_data,
        output composer_erase_start,
        input  composer_erase_busy,
        input  composer_erase_abort
    );

    modport slave (
        input  active_render_buffer,
        input  renderer_rd_idx,
        output renderer_rd_data,
        input  renderer_wr_idx,
        input  renderer_wr_data,
        input  renderer_wr_en,
        input  composer_rd_idx,
        output composer_rd_data,
        input  composer_erase_start,
        output composer_erase_busy,
        output composer_erase_abort
    );
endinterface

// File: rtl/sprite_linebuf_banked_bankset.sv
// One line buffer: BANKS interleaved RAMs, two registered read ports,
// a single-pixel write port and a full-width erase port.
module sprite_linebuf_bankset import sprite_linebuf_banked_pkg::*; #(
    parameter int LINE_PIXELS = SPR_LINE_PIXELS,
    parameter int DATA_WIDTH  = SPR_DATA_WIDTH,
    parameter int BANK_BITS   = SPR_BANK_BITS,
    parameter logic [DATA_WIDTH-1:0] ERASE_VALUE = '0,
    localparam int IDX_W   = $clog2(LINE_PIXELS),
    localparam int DEPTH   = LINE_PIXELS / (2 ** BANK_BITS),
    localparam int DADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_erase_en,
    input  logic [DADDR_W-1:0]    i_erase_addr,
    input  logic [IDX_W-1:0]      i_ra_idx,
    input  logic [IDX_W-1:0]      i_rb_idx,
    output logic [DATA_WIDTH-1:0] o_ra_data,
    output logic [DATA_WIDTH-1:0] o_rb_data
);
    localparam int BANKS = 2 ** BANK_BITS;
    localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(LINE_PIXELS);

    logic [DATA_WIDTH-1:0] w_qa [BANKS];
    logic [DATA_WIDTH-1:0] w_qb [BANKS];
    logic                  w_wr_ok;
    logic                  w_ra_ok;
    logic                  w_rb_ok;
    logic [DADDR_W-1:0]    w_wr_addr;
    logic [DADDR_W-1:0]    w_ra_addr;
    logic [DADDR_W-1:0]    w_rb_addr;
    logic [BANK_BITS-1:0]  r_ra_bank;
    logic [BANK_BITS-1:0]  r_rb_bank;
    logic                  r_ra_ok;
    logic                  r_rb_ok;

    assign w_wr_ok   = {1'b0, i_wr_idx} < LIMIT;
    assign w_ra_ok   = {1'b0, i_ra_idx} < LIMIT;
    assign w_rb_ok   = {1'b0, i_rb_idx} < LIMIT;
    assign w_wr_addr = i_wr_idx[IDX_W-1:BANK_BITS];
    // Out-of-range reads park on word 0; the ok flag masks the result.
    assign w_ra_addr = w_ra_ok ? i_ra_idx[IDX_W-1:BANK_BITS] : '0;
    assign w_rb_addr = w_rb_ok ? i_rb_idx[IDX_W-1:BANK_BITS] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ra_bank <= '0;
            r_rb_bank <= '0;
            r_ra_ok   <= 1'b0;
            r_rb_ok   <= 1'b0;
        end else begin
            r_ra_bank <= i_ra_idx[BANK_BITS-1:0];
            r_rb_bank <= i_rb_idx[BANK_BITS-1:0];
            r_ra_ok   <= w_ra_ok;
            r_rb_ok   <= w_rb_ok;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [DATA_WIDTH-1:0] r_qa;
        logic [DATA_WIDTH-1:0] r_qb;
        logic                  w_wr_sel;

        assign w_wr_sel = i_wr_en && w_wr_ok &&
                          (i_wr_idx[BANK_BITS-1:0] == BANK_BITS'(b));

        always_ff @(posedge clk) begin
            if (i_erase_en) begin
                r_mem[i_erase_addr] <= ERASE_VALUE;
            end else if (w_wr_sel) begin
                r_mem[w_wr_addr] <= i_wr_data;
            end
            r_qa <= r_mem[w_ra_addr];
            r_qb <= r_mem[w_rb_addr];
        end

        assign w_qa[b] = r_qa;
        assign w_qb[b] = r_qb;
    end

    assign o_ra_data = r_ra_ok ? w_qa[r_ra_bank] : ERASE_VALUE;
    assign o_rb_data = r_rb_ok ? w_qb[r_rb_bank] : ERASE_VALUE;

endmodule

// File: rtl/sprite_linebuf_banked.sv
// Double-buffered sprite line buffer: A/B routing, swap detect and the
// compose-buffer erase sequencer.
module sprite_linebuf_banked import sprite_linebuf_banked_pkg::*; #(
    parameter int LINE_PIXELS = SPR_LINE_PIXELS,
    parameter int DATA_WIDTH  = SPR_DATA_WIDTH,
    parameter int BANK_BITS   = SPR_BANK_BITS,
    parameter logic [DATA_WIDTH-1:0] ERASE_VALUE = '0
) (
    input logic clk,
    input logic rst,
    sprite_linebuf_banked_if.slave bus
);
    localparam int BANKS   = 2 ** BANK_BITS;
    localparam int DEPTH   = LINE_PIXELS / BANKS;
    localparam int DADDR_W = $clog2(DEPTH);

    logic [0:0]            r_state;
    logic [DADDR_W-1:0]    r_cnt;
    logic                  r_prev_act;
    logic                  w_act;
    logic                  w_swap;
    logic                  w_erasing;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_a_ra;
    logic [DATA_WIDTH-1:0] w_a_rb;
    logic [DATA_WIDTH-1:0] w_b_ra;
    logic [DATA_WIDTH-1:0] w_b_rb;

    assign w_act     = bus.active_render_buffer;
    assign w_swap    = w_act ^ r_prev_act;
    // A swap seen this cycle suppresses the erase write immediately.
    assign w_erasing = (r_state == ST_ERASE) && !w_swap;
    assign w_last    = r_cnt == DADDR_W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_prev_act <= w_act;
        end else begin
            r_prev_act <= w_act;
            if (bus.composer_erase_start) begin
                r_state <= ST_ERASE;
                r_cnt   <= '0;
            end else if (r_state == ST_ERASE) begin
                if (w_swap || w_last) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + DADDR_W'(1);
                end
            end
        end
    end

    assign bus.composer_erase_busy  = w_erasing;
    assign bus.composer_erase_abort = (r_state == ST_ERASE) && w_swap;

    sprite_linebuf_bankset #(
        .LINE_PIXELS (LINE_PIXELS),
        .DATA_WIDTH  (DATA_WIDTH),
        .BANK_BITS   (BANK_BITS),
        .ERASE_VALUE (ERASE_VALUE)
    ) u_buf_a (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (bus.renderer_wr_en && !w_act),
        .i_wr_idx     (bus.renderer_wr_idx),
        .i_wr_data    (bus.renderer_wr_data),
        .i_erase_en   (w_erasing && w_act),
        .i_erase_addr (r_cnt),
        .i_ra_idx     (bus.renderer_rd_idx),
        .i_rb_idx     (bus.composer_rd_idx),
        .o_ra_data    (w_a_ra),
        .o_rb_data    (w_a_rb)
    );

    sprite_linebuf_bankset #(
        .LINE_PIXELS (LINE_PIXELS),
        .DATA_WIDTH  (DATA_WIDTH),
        .BANK_BITS   (BANK_BITS),
        .ERASE_VALUE (ERASE_VALUE)
    ) u_buf_b (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (bus.renderer_wr_en && w_act),
        .i_wr_idx     (bus.renderer_wr_idx),
        .i_wr_data    (bus.renderer_wr_data),
        .i_erase_en   (w_erasing && !w_act),
        .i_erase_addr (r_cnt),
        .i_ra_idx     (bus.renderer_rd_idx),
        .i_rb_idx     (bus.composer_rd_idx),
        .o_ra_data    (w_b_ra),
        .o_rb_data    (w_b_rb)
    );

    assign bus.renderer_rd_data = w_act ? w_b_ra : w_a_ra;
    assign bus.composer_rd_data = w_act ? w_a_rb : w_b_rb;

endmodule

// File: tb/tb_sprite_linebuf_banked.sv
// Directed bench: default 640x16 instance plus a 320x8, 8-bank, 0xFF-erase instance.
module tb_sprite_linebuf_banked;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sprite_linebuf_banked_if #(.IDX_W(10), .DATA_WIDTH(16)) bus0 ();
    sprite_linebuf_banked_if #(.IDX_W(9), .DATA_WIDTH(8)) bus1 ();

    sprite_linebuf_banked u0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    sprite_linebuf_banked #(
        .LINE_PIXELS (320),
        .DATA_WIDTH  (8),
        .BANK_BITS   (3),
        .ERASE_VALUE (8'hFF)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pat_p(int i);
        return 16'(i) ^ 16'hA5A5;
    endfunction

    function automatic logic [15:0] pat_q(int i);
        return 16'(i) ^ 16'h5A5A;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus0.composer_erase_busy !== 1'b0 || bus0.composer_erase_abort !== 1'b0) begin
            failures++;
            $display("FAIL reset0 busy=%b abort=%b exp 0 0",
                     bus0.composer_erase_busy, bus0.composer_erase_abort);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus1.composer_erase_busy !== 1'b0 || bus1.composer_erase_abort !== 1'b0) begin
            failures++;
            $display("FAIL reset1 busy=%b abort=%b exp 0 0",
                     bus1.composer_erase_busy, bus1.composer_erase_abort);
        end
    endtask

    task automatic test_fill_compose();
        bus0.active_render_buffer = 1'b0;
        tick();
        for (int i = 0; i < 640; i++) begin
            bus0.renderer_wr_idx  = 10'(i);
            bus0.renderer_wr_data = pat_p(i);
            bus0.renderer_wr_en   = 1'b1;
            tick();
        end
        bus0.renderer_wr_en = 1'b0;
        bus0.active_render_buffer = 1'b1;
        #1;
        checks++;
        if (bus0.composer_erase_abort !== 1'b0) begin
            failures++;
            $display("FAIL idle_swap_abort got=%b exp=0", bus0.composer_erase_abort);
        end
        tick();
        for (int i = 0; i < 640; i++) begin
            bus0.renderer_wr_idx  = 10'(i);
            bus0.renderer_wr_data = pat_q(i);
            bus0.renderer_wr_en   = 1'b1;
            tick();
        end
        bus0.renderer_wr_en = 1'b0;
        for (int i = 0; i < 640; i++) begin
            bus0.composer_rd_idx = 10'(i);
            bus0.renderer_rd_idx = 10'(i);
            tick();
            checks++;
            if (bus0.composer_rd_data !== pat_p(i)) begin
                failures++;
                $display("FAIL fill_comp idx=%0d got=%h exp=%h",
                         i, bus0.composer_rd_data, pat_p(i));
            end
            checks++;
            if (bus0.renderer_rd_data !== pat_q(i)) begin
                failures++;
                $display("FAIL fill_rend idx=%0d got=%h exp=%h",
                         i, bus0.renderer_rd_data, pat_q(i));
            end
        end
    endtask

    task automatic test_collision_oor();
        bus0.renderer_rd_idx  = 10'd5;
        bus0.renderer_wr_idx  = 10'd5;
        bus0.renderer_wr_data = 16'h1234;
        bus0.renderer_wr_en   = 1'b1;
        tick();
        bus0.renderer_wr_en = 1'b0;
        checks++;
        if (bus0.renderer_rd_data !== pat_q(5)) begin
            failures++;
            $display("FAIL rw_old got=%h exp=%h", bus0.renderer_rd_data, pat_q(5));
        end
        tick();
        checks++;
        if (bus0.renderer_rd_data !== 16'h1234) begin
            failures++;
            $display("FAIL rw_new got=%h exp=1234", bus0.renderer_rd_data);
        end
        bus0.renderer_wr_data = pat_q(5);
        bus0.renderer_wr_en   = 1'b1;
        tick();
        bus0.renderer_wr_en   = 1'b0;
        bus0.composer_rd_idx  = 10'd641;
        bus0.renderer_rd_idx  = 10'd1023;
        tick();
        checks++;
        if (bus0.composer_rd_data !== 16'h0000 || bus0.renderer_rd_data !== 16'h0000) begin
            failures++;
            $display("FAIL oor_read comp=%h rend=%h exp 0000 0000",
                     bus0.composer_rd_data, bus0.renderer_rd_data);
        end
    endtask

    task automatic test_erase();
        bus0.composer_erase_start = 1'b1;
        #1;
        checks++;
        if (bus0.composer_erase_busy !== 1'b0) begin
            failures++;
            $display("FAIL erase_c0 busy=%b exp=0", bus0.composer_erase_busy);
        end
        for (int c = 1; c <= 161; c++) begin
            tick();
            if (c == 1) bus0.composer_erase_start = 1'b0;
            checks++;
            if (bus0.composer_erase_busy !== (c <= 160) ||
                bus0.composer_erase_abort !== 1'b0) begin
                failures++;
                $display("FAIL erase_busy c=%0d busy=%b abort=%b exp %b 0", c,
                         bus0.composer_erase_busy, bus0.composer_erase_abort, c <= 160);
            end
        end
        for (int i = 0; i < 640; i++) begin
            bus0.composer_rd_idx = 10'(i);
            bus0.renderer_rd_idx = 10'(i);
            tick();
            checks++;
            if (bus0.composer_rd_data !== 16'h0000) begin
                failures++;
                $display("FAIL erased_comp idx=%0d got=%h exp=0000",
                         i, bus0.composer_rd_data);
            end
            checks++;
            if (bus0.renderer_rd_data !== pat_q(i)) begin
                failures++;
                $display("FAIL untouched_rend idx=%0d got=%h exp=%h",
                         i, bus0.renderer_rd_data, pat_q(i));
            end
        end
    endtask

    task automatic test_swap_abort();
        logic [15:0] exp;
        bus0.active_render_buffer = 1'b0;
        tick();
        bus0.composer_erase_start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (c == 1) bus0.composer_erase_start = 1'b0;
            checks++;
            if (bus0.composer_erase_busy !== 1'b1 || bus0.composer_erase_abort !== 1'b0) begin
                failures++;
                $display("FAIL swap_pre c=%0d busy=%b abort=%b exp 1 0", c,
                         bus0.composer_erase_busy, bus0.composer_erase_abort);
            end
        end
        bus0.active_render_buffer = 1'b1;
        #1;
        checks++;
        if (bus0.composer_erase_busy !== 1'b0 || bus0.composer_erase_abort !== 1'b1) begin
            failures++;
            $display("FAIL swap_abort busy=%b abort=%b exp 0 1",
                     bus0.composer_erase_busy, bus0.composer_erase_abort);
        end
        tick();
        checks++;
        if (bus0.composer_erase_busy !== 1'b0 || bus0.composer_erase_abort !== 1'b0) begin
            failures++;
            $display("FAIL swap_after busy=%b abort=%b exp 0 0",
                     bus0.composer_erase_busy, bus0.composer_erase_abort);
        end
        for (int i = 0; i < 640; i++) begin
            bus0.renderer_rd_idx = 10'(i);
            tick();
            exp = (i < 196) ? 16'h0000 : pat_q(i);
            checks++;
            if (bus0.renderer_rd_data !== exp) begin
                failures++;
                $display("FAIL partial idx=%0d got=%h exp=%h",
                         i, bus0.renderer_rd_data, exp);
            end
        end
    endtask

    task automatic test_restart();
        bus0.composer_erase_start = 1'b1;
        for (int c = 1; c <= 261; c++) begin
            tick();
            if (c == 1) bus0.composer_erase_start = 1'b0;
            checks++;
            if (bus0.composer_erase_busy !== (c <= 260) ||
                bus0.composer_erase_abort !== 1'b0) begin
                failures++;
                $display("FAIL restart c=%0d busy=%b abort=%b exp %b 0", c,
                         bus0.composer_erase_busy, bus0.composer_erase_abort, c <= 260);
            end
            if (c == 100) bus0.composer_erase_start = 1'b1;
            if (c == 101) bus0.composer_erase_start = 1'b0;
        end
    endtask

    task automatic test_swap_start();
        bus0.composer_erase_start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) bus0.composer_erase_start = 1'b0;
        end
        bus0.active_render_buffer = 1'b0;
        bus0.composer_erase_start = 1'b1;
        #1;
        checks++;
        if (bus0.composer_erase_busy !== 1'b0 || bus0.composer_erase_abort !== 1'b1) begin
            failures++;
            $display("FAIL swst_abort busy=%b abort=%b exp 0 1",
                     bus0.composer_erase_busy, bus0.composer_erase_abort);
        end
        for (int c = 1; c <= 161; c++) begin
            tick();
            if (c == 1) bus0.composer_erase_start = 1'b0;
            checks++;
            if (bus0.composer_erase_busy !== (c <= 160) ||
                bus0.composer_erase_abort !== 1'b0) begin
                failures++;
                $display("FAIL swst_busy c=%0d busy=%b abort=%b exp %b 0", c,
                         bus0.composer_erase_busy, bus0.composer_erase_abort, c <= 160);
            end
        end
        for (int i = 0; i < 640; i++) begin
            bus0.composer_rd_idx = 10'(i);
            tick();
            checks++;
            if (bus0.composer_rd_data !== 16'h0000) begin
                failures++;
                $display("FAIL swst_comp idx=%0d got=%h exp=0000",
                         i, bus0.composer_rd_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus0.composer_erase_start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1) bus0.composer_erase_start = 1'b0;
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus0.composer_erase_busy !== 1'b0 || bus0.composer_erase_abort !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid busy=%b abort=%b exp 0 0",
                     bus0.composer_erase_busy, bus0.composer_erase_abort);
        end
        rst = 1'b0;
        tick();
        bus0.composer_erase_start = 1'b1;
        for (int c = 1; c <= 161; c++) begin
            tick();
            if (c == 1) bus0.composer_erase_start = 1'b0;
            checks++;
            if (bus0.composer_erase_busy !== (c <= 160) ||
                bus0.composer_erase_abort !== 1'b0) begin
                failures++;
                $display("FAIL rst_after c=%0d busy=%b abort=%b exp %b 0", c,
                         bus0.composer_erase_busy, bus0.composer_erase_abort, c <= 160);
            end
        end
    endtask

    task automatic test_cfg2();
        logic [7:0] exp;
        bus1.active_render_buffer = 1'b0;
        tick();
        for (int i = 0; i < 320; i++) begin
            bus1.renderer_wr_idx  = 9'(i);
            bus1.renderer_wr_data = 8'(i) ^ 8'h3C;
            bus1.renderer_wr_en   = 1'b1;
            tick();
        end
        bus1.renderer_wr_en = 1'b0;
        bus1.active_render_buffer = 1'b1;
        tick();
        for (int i = 0; i < 320; i++) begin
            bus1.composer_rd_idx = 9'(i);
            tick();
            exp = 8'(i) ^ 8'h3C;
            checks++;
            if (bus1.composer_rd_data !== exp) begin
                failures++;
                $display("FAIL cfg2_fill idx=%0d got=%h exp=%h",
                         i, bus1.composer_rd_data, exp);
            end
        end
        bus1.composer_erase_start = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            tick();
            if (c == 1) bus1.composer_erase_start = 1'b0;
            checks++;
            if (bus1.composer_erase_busy !== (c <= 40)) begin
                failures++;
                $display("FAIL cfg2_busy c=%0d got=%b exp=%b",
                         c, bus1.composer_erase_busy, c <= 40);
            end
        end
        for (int i = 0; i <= 320; i++) begin
            bus1.composer_rd_idx = (i == 320) ? 9'd400 : 9'(i);
            tick();
            checks++;
            if (bus1.composer_rd_data !== 8'hFF) begin
                failures++;
                $display("FAIL cfg2_erased idx=%0d got=%h exp=ff",
                         i, bus1.composer_rd_data);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus0.active_render_buffer = 1'b0;
        bus0.renderer_rd_idx      = '0;
        bus0.renderer_wr_idx      = '0;
        bus0.renderer_wr_data     = '0;
        bus0.renderer_wr_en       = 1'b0;
        bus0.composer_rd_idx      = '0;
        bus0.composer_erase_start = 1'b0;
        bus1.active_render_buffer = 1'b0;
        bus1.renderer_rd_idx      = '0;
        bus1.renderer_wr_idx      = '0;
        bus1.renderer_wr_data     = '0;
        bus1.renderer_wr_en       = 1'b0;
        bus1.composer_rd_idx      = '0;
        bus1.composer_erase_start = 1'b0;
        test_reset();
        test_fill_compose();
        test_collision_oor();
        test_erase();
        test_swap_abort();
        test_restart();
        test_swap_start();
        test_reset_mid();
        test_cfg2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
